mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared 4:1 datapath select.
- Four requesters compete for one downstream consumer, e.g. a shared writeback or memory port.
- The block selects a winner, drives the 4:1 select code, and captures the winner's data into an output register.
- The output register is held under a valid/ready handshake until the consumer accepts it.

Parameters:
- WIDTH, 64, data width of each requester and of the output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  4  per-requester valid.
- req_data  input  4*WIDTH  requester i data in bits [i*WIDTH +: WIDTH].
- req_ready  output  4  one-hot, combinational; bit i high when requester i's data is taken this cycle.
- req_lock  input  4  per-requester burst lock; used only with MUX4_ARB_LOCK_EN.
- out_valid  output  1  output register holds data.
- out_data  output  WIDTH  registered winner data.
- out_ready  input  1  consumer accepts out_data.
- sel  output  2  registered index of the current/last winner (select code).
- grant  output  4  registered one-hot of the current winner; 0 when idle.

Behaviour:
- Reset is synchronous, active-high, and overrides everything in the same edge. It clears:
  - state to IDLE, rr_ptr to 0, out_valid to 0, out_data to 0, sel to 2'b00, grant to 4'b0000.
  - Any in-flight data is discarded, even mid-transfer.
  - req_ready is 0 while reset is high.
- Load slot: `load = (state==IDLE) | (state==BUSY & out_ready)`.
- Winner selection:
  - Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod 4.
  - Scanning wraps 3 -> 0.
- req_ready[winner] = load & |req_valid. All other req_ready bits are 0.
- On an edge where load & |req_valid:
  - out_data <= req_data[winner]; out_valid <= 1.
  - sel <= winner; grant <= onehot(winner).
  - rr_ptr <= winner+1 mod 4; state <= BUSY.
- On an edge where load & no req_valid:
  - out_valid <= 0; grant <= 0; state <= IDLE.
  - sel and out_data hold their last values.
- BUSY with out_ready=0: all registers hold; req_ready = 0.
- Latency: data is accepted in cycle N and appears on out_valid/out_data in cycle N+1.
- Back-to-back: when out_ready and a new winner coincide in BUSY, the register reloads in the same edge. Sustained throughput is one transfer per cycle.
- Fairness: with all four valid continuously and out_ready=1, the grant sequence is 0,1,2,3,0,... Each requester waits at most 3 transfers.
- The winner's req_valid dropping after acceptance has no effect; data is already captured.
- A requester asserting req_valid in the same cycle as load competes immediately. Data must be stable while req_valid is high and req_ready is low.
- States are IDLE and BUSY only. The only transitions are those listed above.

Optional Feature:
- Macro: MUX4_ARB_LOCK_EN.
- Defined: lock behaviour.
  - If req_lock[winner] is high at acceptance, a lock flag is set and rr_ptr is NOT advanced (rr_ptr <= winner).
  - The next arbitration grants the same requester if it is valid, even when others are valid.
  - Lock clears when that requester is accepted with req_lock low, or is not valid at a load slot. In that case normal round-robin resumes from winner+1.
  - Reset clears the lock flag.
- Undefined: req_lock is ignored and pure round-robin applies.

Test Plan:
- Reset mid-BUSY: load A5 from req0 with out_ready=0, then assert reset for 1 cycle -> out_valid=0, grant=0000, sel=00, out_data=0. The next arbitration starts from requester 0.
- Single requester: req_valid=0100, data 0x1234, out_ready=1 -> req_ready=0100 in cycle N. Cycle N+1: out_valid=1, out_data=0x1234, sel=10, grant=0100. With no further requests, IDLE at N+2.
- Round-robin with wrap: all four valid, data 10/11/12/13, out_ready=1 -> out_data sequence 10,11,12,13,10 on consecutive cycles. sel sequence 0,1,2,3,0.
- Backpressure: two requesters valid, out_ready=0 for 3 cycles -> out_data and req_ready stay frozen. Releasing out_ready gives one transfer per cycle with no data loss or duplication.
- Pointer fairness: req1 alone granted, then req_valid=1011 -> next grant is req3, then req0, then req1.
- Lock (MUX4_ARB_LOCK_EN): all four valid, req_lock=0010 -> req1 granted 3 consecutive times while its lock is held. After req1 is accepted with its lock low, req2 is granted. Without the macro, the same stimulus gives grants 0,1,2,3.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four requesters sharing one registered 4:1 output with valid/ready.
// Optional burst lock (keeps granting the same requester) is enabled with MUX4_ARB_LOCK_EN.
module mux4_rr_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         req_valid,
    input  logic [4*WIDTH-1:0] req_data,
    output logic [3:0]         req_ready,
    input  logic [3:0]         req_lock,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    input  logic               out_ready,
    output logic [1:0]         sel,
    output logic [3:0]         grant
);

    // state | meaning
    // IDLE  | output register empty, any valid requester is taken at once
    // BUSY  | output register full, reloads only when the consumer accepts
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [1:0] rr_ptr_q;
    logic [1:0] rr_ptr_d;
    logic       load;
    logic       any_valid;
    logic       take;
    logic [1:0] winner;
    logic [3:0] winner_oh;

    assign any_valid = |req_valid;
    assign load      = (state_q == IDLE) | ((state_q == BUSY) & out_ready);
    assign take      = load & any_valid;
    assign winner_oh = 4'b0001 << winner;
    assign req_ready = (take & ~reset) ? winner_oh : 4'b0000;

    // Scan from the farthest slot down so the one nearest rr_ptr wins.
    always_comb begin
        logic [1:0] idx;
        winner = rr_ptr_q;
        idx    = rr_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = rr_ptr_q + 2'(k);
            if (req_valid[idx]) begin
                winner = idx;
            end
        end
    end

`ifdef MUX4_ARB_LOCK_EN
    logic lock_q;
    logic lock_d;

    // A locked winner parks the pointer on itself; releasing moves past it.
    always_comb begin
        lock_d   = lock_q;
        rr_ptr_d = rr_ptr_q;
        if (take) begin
            if (req_lock[winner]) begin
                lock_d   = 1'b1;
                rr_ptr_d = winner;
            end else begin
                lock_d   = 1'b0;
                rr_ptr_d = winner + 2'd1;
            end
        end else if (load & lock_q) begin
            lock_d   = 1'b0;
            rr_ptr_d = rr_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (take) begin
            rr_ptr_d = winner + 2'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (load & ~any_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q  <= 2'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sel       <= 2'd0;
            grant     <= 4'b0000;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (take) begin
                out_data  <= req_data[int'(winner)*WIDTH +: WIDTH];
                out_valid <= 1'b1;
                sel       <= winner;
                grant     <= winner_oh;
            end else if (load) begin
                // Nothing to take: drop valid, keep sel/out_data as last winner.
                out_valid <= 1'b0;
                grant     <= 4'b0000;
            end
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: vector table, directed corner sequences,
// then random traffic against a behavioural model (honours MUX4_ARB_LOCK_EN if defined).
module tb_mux4_rr_arbiter;

    localparam int WIDTH = 64;
`ifdef MUX4_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic               clk;
    logic               reset;
    logic [3:0]         req_valid;
    logic [4*WIDTH-1:0] req_data;
    logic [3:0]         req_ready;
    logic [3:0]         req_lock;
    logic               out_valid;
    logic [WIDTH-1:0]   out_data;
    logic               out_ready;
    logic [1:0]         sel;
    logic [3:0]         grant;

    logic [63:0] dat [4];
    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    int n_chk;
    int n_fail;

    mux4_rr_arbiter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .req_lock  (req_lock),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  v;
        logic        r;
        logic [3:0]  e_rdy;
        logic        e_ov;
        logic [1:0]  e_sel;
        logic [3:0]  e_gnt;
        logic [63:0] e_dat;
    } vec_t;

    vec_t tbl [11];

    // behavioural model state
    int          m_ptr;
    bit          m_busy;
    bit          m_lock;
    logic        m_ov;
    logic [1:0]  m_sel;
    logic [3:0]  m_gnt;
    logic [63:0] m_dat;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic put(input logic [3:0] v, input logic r, input logic rs);
        req_valid = v;
        out_ready = r;
        reset     = rs;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ov, input logic [1:0] s,
                              input logic [3:0] g, input logic [63:0] d);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        chk({tag, ".sel"},       64'(sel),       64'(s));
        chk({tag, ".grant"},     64'(grant),     64'(g));
        chk({tag, ".out_data"},  out_data,       d);
    endtask

    task automatic do_reset;
        put(4'b0000, 1'b0, 1'b1);
        tick;
    endtask

    initial begin
        int exp_g [6];
        n_chk     = 0;
        n_fail    = 0;
        req_valid = '0;
        req_lock  = '0;
        out_ready = 1'b0;
        reset     = 1'b1;
        for (int i = 0; i < 4; i++) dat[i] = 64'h0;

        // ---------------- reset state ----------------
        put(4'b1111, 1'b1, 1'b1);
        chk("reset.req_ready", 64'(req_ready), 64'h0);
        tick;
        expect_out("reset", 1'b0, 2'd0, 4'b0000, 64'h0);

        // ---------------- vector table ----------------
        tbl[0]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2, 4'b0100, 64'h1002};
        tbl[1]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd2, 4'b0000, 64'h1002};
        tbl[2]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b1000, 64'h1003};
        tbl[3]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0, 4'b0001, 64'h1000};
        tbl[4]  = '{4'b1111, 1'b0, 4'b0000, 1'b1, 2'd0, 4'b0001, 64'h1000};
        tbl[5]  = '{4'b1010, 1'b1, 4'b0010, 1'b1, 2'd1, 4'b0010, 64'h1001};
        tbl[6]  = '{4'b1010, 1'b1, 4'b1000, 1'b1, 2'd3, 4'b1000, 64'h1003};
        tbl[7]  = '{4'b0001, 1'b0, 4'b0000, 1'b1, 2'd3, 4'b1000, 64'h1003};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3, 4'b0000, 64'h1003};
        tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3, 4'b0000, 64'h1003};
        tbl[10] = '{4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 4'b0010, 64'h1001};
        for (int i = 0; i < 4; i++) dat[i] = 64'h1000 + 64'(i);
        do_reset;
        for (int n = 0; n < 11; n++) begin
            put(tbl[n].v, tbl[n].r, 1'b0);
            chk($sformatf("tbl%0d.req_ready", n), 64'(req_ready), 64'(tbl[n].e_rdy));
            tick;
            expect_out($sformatf("tbl%0d", n), tbl[n].e_ov, tbl[n].e_sel, tbl[n].e_gnt, tbl[n].e_dat);
        end

        // ---------------- reset mid-BUSY ----------------
        do_reset;
        dat[0] = 64'hA5;
        put(4'b0001, 1'b0, 1'b0);
        tick;
        chk("midrst.loaded", out_data, 64'hA5);
        put(4'b1111, 1'b1, 1'b1);
        chk("midrst.req_ready_in_reset", 64'(req_ready), 64'h0);
        tick;
        expect_out("midrst", 1'b0, 2'd0, 4'b0000, 64'h0);
        put(4'b1111, 1'b1, 1'b0);
        chk("midrst.restart_ready", 64'(req_ready), 64'b0001);
        tick;
        chk("midrst.restart_sel", 64'(sel), 64'd0);

        // ---------------- single requester ----------------
        put(4'b0000, 1'b1, 1'b0);
        tick;
        dat[2] = 64'h1234;
        put(4'b0100, 1'b1, 1'b0);
        chk("single.req_ready", 64'(req_ready), 64'b0100);
        tick;
        expect_out("single.n1", 1'b1, 2'd2, 4'b0100, 64'h1234);
        put(4'b0000, 1'b1, 1'b0);
        tick;
        expect_out("single.n2", 1'b0, 2'd2, 4'b0000, 64'h1234);

        // ---------------- round robin with wrap ----------------
        do_reset;
        for (int i = 0; i < 4; i++) dat[i] = 64'h10 + 64'(i);
        for (int k = 0; k < 5; k++) begin
            put(4'b1111, 1'b1, 1'b0);
            tick;
            chk($sformatf("rr%0d.out_data", k), out_data, 64'h10 + 64'(k % 4));
            chk($sformatf("rr%0d.sel", k), 64'(sel), 64'(k % 4));
        end

        // ---------------- backpressure ----------------
        do_reset;
        for (int i = 0; i < 4; i++) dat[i] = 64'h20 + 64'(i);
        put(4'b0101, 1'b0, 1'b0);
        chk("bp.first_ready", 64'(req_ready), 64'b0001);
        tick;
        for (int k = 0; k < 3; k++) begin
            put(4'b0100, 1'b0, 1'b0);
            chk($sformatf("bp%0d.req_ready", k), 64'(req_ready), 64'h0);
            tick;
            expect_out($sformatf("bp%0d", k), 1'b1, 2'd0, 4'b0001, 64'h20);
        end
        put(4'b0100, 1'b1, 1'b0);
        chk("bp.release_ready", 64'(req_ready), 64'b0100);
        tick;
        expect_out("bp.second", 1'b1, 2'd2, 4'b0100, 64'h22);
        put(4'b0000, 1'b1, 1'b0);
        tick;
        chk("bp.drained", 64'(out_valid), 64'h0);

        // ---------------- pointer fairness ----------------
        do_reset;
        put(4'b0010, 1'b1, 1'b0);
        tick;
        chk("fair.first_sel", 64'(sel), 64'd1);
        exp_g[0] = 3; exp_g[1] = 0; exp_g[2] = 1;
        for (int k = 0; k < 3; k++) begin
            put(4'b1011, 1'b1, 1'b0);
            chk($sformatf("fair%0d.req_ready", k), 64'(req_ready), 64'(4'b0001 << exp_g[k]));
            tick;
            chk($sformatf("fair%0d.sel", k), 64'(sel), 64'(exp_g[k]));
        end

        // ---------------- lock ----------------
        do_reset;
        for (int i = 0; i < 4; i++) dat[i] = 64'h30 + 64'(i);
        if (LOCK_ON) begin
            exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 1; exp_g[3] = 1; exp_g[4] = 1; exp_g[5] = 2;
        end else begin
            exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2; exp_g[3] = 3; exp_g[4] = 0; exp_g[5] = 1;
        end
        for (int k = 0; k < 6; k++) begin
            req_lock = (k < 4) ? 4'b0010 : 4'b0000;
            put(4'b1111, 1'b1, 1'b0);
            tick;
            chk($sformatf("lock%0d.grant", k), 64'(grant), 64'(4'b0001 << exp_g[k]));
            chk($sformatf("lock%0d.out_data", k), out_data, 64'h30 + 64'(exp_g[k]));
        end
        req_lock = 4'b0000;

        // ---------------- random traffic vs model ----------------
        do_reset;
        m_ptr = 0; m_busy = 0; m_lock = 0;
        m_ov = 0; m_sel = 0; m_gnt = 0; m_dat = 0;
        for (int c = 0; c < 400; c++) begin
            logic [3:0] v;
            logic [3:0] lk;
            logic       r;
            logic       rs;
            bit         ld;
            int         w;
            v  = 4'($urandom);
            lk = 4'($urandom);
            r  = ($urandom % 4) != 0;
            rs = ($urandom % 50) == 0;
            for (int i = 0; i < 4; i++) dat[i] = {$urandom, $urandom};
            req_lock = lk;
            put(v, r, rs);

            ld = !m_busy || r;
            w  = -1;
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && v[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            chk($sformatf("rnd%0d.req_ready", c), 64'(req_ready),
                (!rs && ld && w >= 0) ? 64'(4'b0001 << w) : 64'h0);
            tick;

            if (rs) begin
                m_ptr = 0; m_busy = 0; m_lock = 0;
                m_ov = 0; m_sel = 0; m_gnt = 0; m_dat = 0;
            end else if (ld && w >= 0) begin
                m_dat  = dat[w];
                m_ov   = 1;
                m_sel  = 2'(w);
                m_gnt  = 4'(1 << w);
                m_busy = 1;
                if (LOCK_ON && lk[w]) begin
                    m_lock = 1;
                    m_ptr  = w;
                end else begin
                    m_lock = 0;
                    m_ptr  = (w + 1) % 4;
                end
            end else if (ld) begin
                m_ov   = 0;
                m_gnt  = 0;
                m_busy = 0;
                if (m_lock) begin
                    m_lock = 0;
                    m_ptr  = (m_ptr + 1) % 4;
                end
            end
            expect_out($sformatf("rnd%0d", c), m_ov, m_sel, m_gnt, m_dat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
